// File: rtl/sme_pkg.sv
// Shared constants, character codes and FSM state type for the string matching engine.
package sme_pkg;

    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;
    localparam int CW      = 8;
    localparam int IDX_W   = $clog2(STR_MAX);
    localparam int POS_W   = IDX_W + 1;
    localparam int PIDX_W  = $clog2(PAT_MAX);
    localparam int PLEN_W  = PIDX_W + 1;

    typedef logic [CW-1:0] char_t;

    localparam char_t CH_DOT    = 8'h2E;
    localparam char_t CH_CARET  = 8'h5E;
    localparam char_t CH_DOLLAR = 8'h24;
    localparam char_t CH_STAR   = 8'h2A;
    localparam char_t CH_SPACE  = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_STR,
        ST_LOAD_PAT,
        ST_MATCH,
        ST_OUT
    } sme_state_e;

endpackage

// File: rtl/sme_if.sv
// Byte-serial host bus of the string matching engine: character feed in, match result out.
interface sme_if;
    import sme_pkg::*;

    char_t            chardata;
    logic             isstring;
    logic             ispattern;
    logic             valid;
    logic             match;
    logic [IDX_W-1:0] match_index;

    modport master (
        output chardata, isstring, ispattern,
        input  valid, match, match_index
    );

    modport slave (
        input  chardata, isstring, ispattern,
        output valid, match, match_index
    );

endinterface

// File: rtl/sme_window_cmp.sv
// Combinational compare of one pattern segment against the string anchored at position s.
// Column j of the segment lines up with string position s + j (minus one when a leading '^' is active).
module sme_window_cmp
    import sme_pkg::*;
(
    input  char_t             str_mem [STR_MAX],
    input  logic [POS_W-1:0]  str_len,
    input  char_t             pat_mem [PAT_MAX],
    input  logic [PLEN_W-1:0] seg_start,
    input  logic [PLEN_W-1:0] seg_len,
    input  logic              caret_en,
    input  logic              dollar_en,
    input  logic [POS_W-1:0]  s,
    output logic              hit,
    output logic [PLEN_W-1:0] match_len
);

    localparam int PW = POS_W + 1;

    logic [PAT_MAX-1:0] ok;
    logic [POS_W-1:0]   s_prev;
    logic               caret_ok;

    // '^' is satisfied at the string start or right after a space.
    assign s_prev   = s - POS_W'(1);
    assign caret_ok = (s == '0) || (str_mem[s_prev[IDX_W-1:0]] == CH_SPACE);

    generate
        for (genvar gi = 0; gi < PAT_MAX; gi++) begin : g_col
            localparam logic [PLEN_W-1:0] COL = PLEN_W'(gi);

            logic [PLEN_W-1:0] pidx;
            logic [PW-1:0]     pos;
            logic              in_str;
            logic              at_end;
            char_t             pc;
            char_t             sc;
            logic              col_ok;

            assign pidx   = seg_start + COL;
            assign pc     = pat_mem[pidx[PIDX_W-1:0]];
            assign pos    = {1'b0, s} + PW'(gi) - PW'(caret_en);
            assign in_str = pos < {1'b0, str_len};
            assign at_end = pos == {1'b0, str_len};
            assign sc     = str_mem[pos[IDX_W-1:0]];

            always_comb begin
                col_ok = 1'b1;
                if (COL >= seg_len) begin
                    col_ok = 1'b1;
                end else if (gi == 0 && caret_en) begin
                    col_ok = caret_ok;
                end else if (COL == seg_len - PLEN_W'(1) && dollar_en) begin
                    col_ok = at_end || (in_str && sc == CH_SPACE);
                end else begin
                    col_ok = in_str && (pc == CH_DOT || pc == sc);
                end
            end

            assign ok[gi] = col_ok;
        end
    endgenerate

    assign hit       = &ok;
    // Number of string characters the segment body consumes (anchors excluded).
    assign match_len = seg_len - PLEN_W'(caret_en) - PLEN_W'(dollar_en);

endmodule

// File: rtl/sme_engine.sv
// String matching engine: loads a string and patterns byte-serially, scans one start position per cycle.
// Optional '*' wildcard support is compiled in with SME_STAR_EN.
module sme_engine
    import sme_pkg::*;
(
    input  logic clk,
    input  logic reset,
    sme_if.slave bus
);

    sme_state_e        state_reg, state_next;
    char_t             str_mem [STR_MAX];
    char_t             pat_mem [PAT_MAX];
    logic [POS_W-1:0]  str_len_reg, str_len_next;
    logic [PLEN_W-1:0] pat_len_reg, pat_len_next;
    logic [POS_W-1:0]  s_reg, s_next;
    logic [POS_W-1:0]  pre_start_reg, pre_start_next;
    logic              phase_reg, phase_next;
    logic              match_reg, match_next;
    logic [IDX_W-1:0]  match_index_reg, match_index_next;

    logic              str_we;
    logic              pat_we;
    logic [IDX_W-1:0]  str_waddr;
    logic [PIDX_W-1:0] pat_waddr;

    logic              star_found;
    logic [PLEN_W-1:0] star_pos;
    logic [PLEN_W-1:0] last_idx;
    char_t             first_ch;
    char_t             last_ch;

    logic [PLEN_W-1:0] seg_start;
    logic [PLEN_W-1:0] seg_len;
    logic              caret_en;
    logic              dollar_en;
    logic              cmp_hit;
    logic [PLEN_W-1:0] cmp_len;

`ifdef SME_STAR_EN
    // Leftmost '*' splits the pattern into prefix and suffix.
    always_comb begin
        star_found = 1'b0;
        star_pos   = '0;
        for (int j = PAT_MAX - 1; j >= 0; j--) begin
            if (PLEN_W'(j) < pat_len_reg && pat_mem[j] == CH_STAR) begin
                star_found = 1'b1;
                star_pos   = PLEN_W'(j);
            end
        end
    end
`else
    assign star_found = 1'b0;
    assign star_pos   = '0;
`endif

    assign last_idx = pat_len_reg - PLEN_W'(1);
    assign first_ch = pat_mem[0];
    assign last_ch  = pat_mem[last_idx[PIDX_W-1:0]];

    // Phase 0 scans the whole pattern (or the prefix); phase 1 scans the suffix after '*'.
    always_comb begin
        seg_start = '0;
        seg_len   = pat_len_reg;
        caret_en  = 1'b0;
        dollar_en = 1'b0;
        if (!phase_reg) begin
            seg_len   = star_found ? star_pos : pat_len_reg;
            caret_en  = (seg_len != '0) && (first_ch == CH_CARET);
            dollar_en = !star_found && (pat_len_reg != '0) && (last_ch == CH_DOLLAR);
        end else begin
            seg_start = star_pos + PLEN_W'(1);
            seg_len   = pat_len_reg - star_pos - PLEN_W'(1);
            dollar_en = (seg_len != '0) && (last_ch == CH_DOLLAR);
        end
    end

    sme_window_cmp u_cmp (
        .str_mem   (str_mem),
        .str_len   (str_len_reg),
        .pat_mem   (pat_mem),
        .seg_start (seg_start),
        .seg_len   (seg_len),
        .caret_en  (caret_en),
        .dollar_en (dollar_en),
        .s         (s_reg),
        .hit       (cmp_hit),
        .match_len (cmp_len)
    );

    always_comb begin
        state_next       = state_reg;
        str_len_next     = str_len_reg;
        pat_len_next     = pat_len_reg;
        s_next           = s_reg;
        pre_start_next   = pre_start_reg;
        phase_next       = phase_reg;
        match_next       = match_reg;
        match_index_next = match_index_reg;
        str_we           = 1'b0;
        pat_we           = 1'b0;
        str_waddr        = str_len_reg[IDX_W-1:0];
        pat_waddr        = pat_len_reg[PIDX_W-1:0];

        case (state_reg)
            ST_IDLE: begin
                if (bus.isstring) begin
                    str_we       = 1'b1;
                    str_waddr    = '0;
                    str_len_next = POS_W'(1);
                    state_next   = ST_LOAD_STR;
                end else if (bus.ispattern) begin
                    pat_we       = 1'b1;
                    pat_waddr    = '0;
                    pat_len_next = PLEN_W'(1);
                    state_next   = ST_LOAD_PAT;
                end
            end
            ST_LOAD_STR: begin
                if (bus.isstring) begin
                    if (str_len_reg < POS_W'(STR_MAX)) begin
                        str_we       = 1'b1;
                        str_len_next = str_len_reg + POS_W'(1);
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_LOAD_PAT: begin
                if (bus.ispattern) begin
                    if (pat_len_reg < PLEN_W'(PAT_MAX)) begin
                        pat_we       = 1'b1;
                        pat_len_next = pat_len_reg + PLEN_W'(1);
                    end
                end else begin
                    s_next     = '0;
                    phase_next = 1'b0;
                    state_next = ST_MATCH;
                end
            end
            ST_MATCH: begin
                if (!phase_reg) begin
                    // An anchor-only segment has nothing to align and hits immediately.
                    if (cmp_hit || cmp_len == '0) begin
                        if (star_found) begin
                            phase_next     = 1'b1;
                            pre_start_next = s_reg;
                            s_next         = s_reg + POS_W'(cmp_len);
                        end else begin
                            match_next       = 1'b1;
                            match_index_next = s_reg[IDX_W-1:0];
                            state_next       = ST_OUT;
                        end
                    end else if (s_reg + POS_W'(1) >= str_len_reg) begin
                        match_next       = 1'b0;
                        match_index_next = '0;
                        state_next       = ST_OUT;
                    end else begin
                        s_next = s_reg + POS_W'(1);
                    end
                end else begin
                    // Suffix may start at end of string so a lone '$' can still hit.
                    if (cmp_hit) begin
                        match_next       = 1'b1;
                        match_index_next = pre_start_reg[IDX_W-1:0];
                        state_next       = ST_OUT;
                    end else if (s_reg >= str_len_reg) begin
                        match_next       = 1'b0;
                        match_index_next = '0;
                        state_next       = ST_OUT;
                    end else begin
                        s_next = s_reg + POS_W'(1);
                    end
                end
            end
            ST_OUT: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            str_len_reg     <= '0;
            pat_len_reg     <= '0;
            s_reg           <= '0;
            pre_start_reg   <= '0;
            phase_reg       <= 1'b0;
            match_reg       <= 1'b0;
            match_index_reg <= '0;
        end else begin
            state_reg       <= state_next;
            str_len_reg     <= str_len_next;
            pat_len_reg     <= pat_len_next;
            s_reg           <= s_next;
            pre_start_reg   <= pre_start_next;
            phase_reg       <= phase_next;
            match_reg       <= match_next;
            match_index_reg <= match_index_next;
        end
    end

    // Character storage needs no reset: lengths gate every read.
    always_ff @(posedge clk) begin
        if (str_we) begin
            str_mem[str_waddr] <= bus.chardata;
        end
        if (pat_we) begin
            pat_mem[pat_waddr] <= bus.chardata;
        end
    end

    assign bus.valid       = (state_reg == ST_OUT);
    assign bus.match       = match_reg;
    assign bus.match_index = match_index_reg;

endmodule

// File: tb/tb_sme_engine.sv
// Self-checking bench for sme_engine: directed cases plus random strings/patterns against a search model.
module tb_sme_engine;
    import sme_pkg::*;

`ifdef SME_STAR_EN
    localparam int LAT_MAX = 2 * STR_MAX + 4;
`else
    localparam int LAT_MAX = STR_MAX + 3;
`endif

    typedef byte unsigned bq_t[$];

    logic  clk;
    logic  reset;
    int    checks;
    int    errors;
    string cur_str;

    sme_if bus ();

    sme_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bq_t to_q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Does segment seg fit the text with its first body char at anchor a?
    function automatic bit seg_at(input bq_t t, input bq_t seg, input bit first_seg,
                                  input bit last_seg, input int a, output int used);
        int p;
        int k;
        p = a;
        k = 0;
        used = 0;
        if (first_seg && seg.size() > 0 && seg[0] == "^") begin
            if (!(a == 0 || t[a-1] == " ")) return 1'b0;
            k = 1;
        end
        for (; k < seg.size(); k++) begin
            if (last_seg && k == seg.size() - 1 && seg[k] == "$") begin
                if (!(p == t.size() || (p < t.size() && t[p] == " "))) return 1'b0;
            end else begin
                if (p >= t.size()) return 1'b0;
                if (!(seg[k] == "." || seg[k] == t[p])) return 1'b0;
                p++;
            end
        end
        used = p - a;
        return 1'b1;
    endfunction

    function automatic void ref_match(input bq_t t, input bq_t pat, output int m, output int idx);
        int   star;
        int   used;
        int   used2;
        bq_t  pre;
        bq_t  suf;
        m = 0;
        idx = 0;
        star = -1;
        if (pat.size() == 1 && (pat[0] == "^" || pat[0] == "$")) begin
            m = 1;
            return;
        end
`ifdef SME_STAR_EN
        foreach (pat[i]) if (star < 0 && pat[i] == "*") star = i;
`endif
        if (star < 0) begin
            for (int a = 0; a < t.size(); a++) begin
                if (seg_at(t, pat, 1'b1, 1'b1, a, used)) begin
                    m = 1;
                    idx = a;
                    return;
                end
            end
        end else begin
            for (int i = 0; i < star; i++) pre.push_back(pat[i]);
            for (int i = star + 1; i < pat.size(); i++) suf.push_back(pat[i]);
            for (int a = 0; a < t.size(); a++) begin
                if (seg_at(t, pre, 1'b1, 1'b0, a, used)) begin
                    for (int b = a + used; b <= t.size(); b++) begin
                        if (seg_at(t, suf, 1'b0, 1'b1, b, used2)) begin
                            m = 1;
                            idx = a;
                            return;
                        end
                    end
                    return;
                end
            end
        end
    endfunction

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            bus.chardata = s[i];
            bus.isstring = 1'b1;
            @(posedge clk); #1;
        end
        bus.isstring = 1'b0;
        bus.chardata = '0;
        @(posedge clk); #1;
        cur_str = s;
    endtask

    task automatic run_pat(input string p, input int em, input int ei);
        int cyc;
        for (int i = 0; i < p.len(); i++) begin
            bus.chardata  = p[i];
            bus.ispattern = 1'b1;
            @(posedge clk); #1;
        end
        bus.ispattern = 1'b0;
        bus.chardata  = '0;
        cyc = 0;
        while (bus.valid !== 1'b1 && cyc < LAT_MAX) begin
            @(posedge clk); #1;
            cyc++;
        end
        $display("string '%s' pattern '%s': valid=%0d match=%0d index=%0d (expect %0d/%0d) after %0d cycles",
                 cur_str, p, bus.valid, bus.match, bus.match_index, em, ei, cyc);
        check({p, " valid"}, int'(bus.valid), 1);
        check({p, " match"}, int'(bus.match), em);
        check({p, " index"}, int'(bus.match_index), ei);
        @(posedge clk); #1;
        check({p, " valid_pulse_end"}, int'(bus.valid), 0);
        check({p, " match_hold"}, int'(bus.match), em);
    endtask

    task automatic run_model(input string p);
        int em;
        int ei;
        ref_match(to_q(cur_str), to_q(p), em, ei);
        run_pat(p, em, ei);
    endtask

    function automatic string rand_str(input string alpha, input int n);
        string s;
        int    k;
        s = "";
        for (int i = 0; i < n; i++) begin
            k = $urandom_range(0, alpha.len() - 1);
            s = {s, alpha.substr(k, k)};
        end
        return s;
    endfunction

    initial begin
        int    saw_valid;
        bit    car;
        bit    dol;
        string p;

        checks = 0;
        errors = 0;
        cur_str = "";
        reset = 1'b0;
        bus.chardata = '0;
        bus.isstring = 1'b0;
        bus.ispattern = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset valid", int'(bus.valid), 0);
        check("reset match", int'(bus.match), 0);
        check("reset index", int'(bus.match_index), 0);
        reset = 1'b1;
        @(posedge clk); #1;

        send_str("hello world");
        run_pat("wor", 1, 6);
        run_pat("^wor", 1, 6);
        run_pat("^h.l", 1, 0);
        run_pat("llo$", 1, 2);
        run_pat("xyz", 0, 0);
        run_pat("ld$", 1, 9);
        run_pat("^", 1, 0);
        run_pat("$", 1, 0);

        send_str("aaab");
        run_pat("ab", 1, 2);
        run_pat("b$", 1, 3);
        run_pat("aaaba", 0, 0);

`ifdef SME_STAR_EN
        send_str("hello world");
        run_pat("he*ld", 1, 0);
        run_pat("o*z", 0, 0);
        run_pat("l*o", 1, 2);
        run_pat("o*$", 1, 4);
`else
        send_str("a*b");
        run_pat("*b", 1, 1);
`endif

        for (int n = 0; n < 10; n++) begin
            send_str(rand_str("ab ", $urandom_range(1, STR_MAX)));
            for (int k = 0; k < 4; k++) begin
                car = ($urandom_range(0, 3) == 0);
                dol = ($urandom_range(0, 3) == 0);
                p = rand_str("ab .", $urandom_range(1, PAT_MAX - int'(car) - int'(dol)));
                if (car) p = {"^", p};
                if (dol) p = {p, "$"};
                run_model(p);
            end
        end

        // Abort a pattern load with reset; no result may follow.
        send_str("hello world");
        run_pat("wor", 1, 6);
        bus.chardata = "w";
        bus.ispattern = 1'b1;
        @(posedge clk); #1;
        bus.chardata = "o";
        @(posedge clk); #1;
        bus.ispattern = 1'b0;
        bus.chardata = '0;
        reset = 1'b0;
        #1;
        check("abort reset match", int'(bus.match), 0);
        check("abort reset index", int'(bus.match_index), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        saw_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.valid === 1'b1) saw_valid = 1;
        end
        check("abort no valid", saw_valid, 0);
        send_str("abc");
        run_pat("c", 1, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sme_engine.md
Name: sme_engine

Overview:
- String Matching Engine.
- Loads a text string (up to 32 chars), then accepts one or more search patterns (up to 8 chars each) against it.
- After each pattern it reports whether the pattern occurs in the string and the index of the earliest occurrence.
- Standalone byte-serial block, fed one ASCII character per clock by a host.

Parameters:
- STR_MAX, 32, maximum string length in characters (index width = clog2(STR_MAX) = 5).
- PAT_MAX, 8, maximum pattern length in characters.
- CW, 8, character width (ASCII).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- chardata  input  CW  current string or pattern character.
- isstring  input  1  high while chardata carries a string character.
- ispattern  input  1  high while chardata carries a pattern character.
- valid  output  1  one-cycle pulse: match/match_index are valid.
- match  output  1  1 = pattern found in current string.
- match_index  output  5  string index of the first char of the earliest match; 0 when match=0.

Behaviour:
- Reset (reset low, async): valid=0, match=0, match_index=0, string length=0, pattern length=0, FSM to IDLE.
- Input framing:
  - One character is accepted per rising edge while isstring or ispattern is high; the two are never high together.
  - A string is a contiguous isstring burst. The first isstring cycle after any non-isstring cycle clears the stored string and starts a new one at index 0.
  - A pattern is a contiguous ispattern burst, stored the same way.
  - The falling edge of ispattern (pattern complete) starts matching.
- Multiple patterns may follow one string. The string is retained until the next isstring burst.
- The host holds inputs low until valid has pulsed.
- FSM states:
  - IDLE -> LOAD_STR on isstring; -> LOAD_PAT on ispattern.
  - LOAD_STR -> IDLE when isstring drops.
  - LOAD_PAT -> MATCH when ispattern drops.
  - MATCH scans start positions s = 0 .. strlen-1, one per cycle, comparing all pattern chars in parallel. It exits on the first hit or after the last s.
  - OUT drives valid=1 for exactly one cycle, then -> IDLE.
  - Latency from the ispattern falling edge to valid: at most STR_MAX+3 cycles.
- Pattern metacharacters:
  - '.' matches any single character, including space.
  - '^' (first pattern char only) matches position 0 of the string, or a space character. The reported index is the char after '^'.
  - '$' (last pattern char only) matches end of string or a space character.
  - All other characters match by exact 8-bit compare.
- match_index:
  - Equals the string position aligned with the first non-'^' pattern char.
  - For '^' at the string start, index = 0. For '^' matching a space at position p, index = p+1.
- Boundaries:
  - A pattern longer than the remaining string does not match, except where a trailing '$' consumes end of string.
  - A pattern of only '^' or only '$' matches with index 0.
  - Outputs keep their values between valid pulses.
  - Reset mid-load or mid-match aborts the operation with no valid pulse.

Optional Feature:
- Macro: SME_STAR_EN.
- Defined: '*' in a pattern (at most one) matches any sequence of zero or more characters.
  - Prefix and suffix are matched in order: earliest prefix first, then the earliest suffix after it.
  - match_index = index of the prefix start.
  - Latency bound becomes 2*STR_MAX+4.
- Undefined: '*' is an ordinary literal character.

Decomposition:
- Package sme_pkg holds:
  - STR_MAX, PAT_MAX, CW.
  - Character constants CH_DOT, CH_CARET, CH_DOLLAR, CH_STAR, CH_SPACE.
  - FSM state enum.
- One sub-module, sme_window_cmp: combinational comparison of a PAT_MAX window of the string at offset s against the pattern. Outputs hit and matched length.

Test Plan:
- String "hello world", pattern "wor" -> valid pulse; match=1, match_index=6.
- Same string, pattern "^wor" -> 1, 6. Pattern "^h.l" -> 1, 0. Pattern "llo$" -> 1, 2 ('$' matches the space).
- Same string, pattern "xyz" -> 0, 0. Pattern "ld$" -> 1, 9.
- New string "aaab", pattern "ab" -> 1, 2. Then a second pattern "b$" with no new string -> 1, 3 (string retained).
- Reset asserted mid-pattern -> no valid pulse. A fresh string "abc" plus pattern "c" then gives 1, 2.
- SME_STAR_EN defined: string "hello world", pattern "he*ld" -> 1, 0. Pattern "o*z" -> 0, 0.
